fetch_queue: RTL and testbench

Instruction-fetch front end between the instruction memory port and the pipeline's Fetch/Decode boundary. It prefetches sequential instructions into a small FIFO over a request/grant/response handshake. It presents one `{PC, instruction}` pair per cycle to the Fetch stage, honouring `StallF`. On a taken branch or jump (`PCSrcE`), it flushes the queue and discards in-flight memory responses.

---
 rtl/fetch_queue.sv | 101 ++++++++++
 tb/tb_fetch_queue.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: prefetching instruction FIFO between imem and Fetch, flushed on redirect.
// Optional FETCHQ_STATS_EN adds the saturating fetch_bubble_cnt output.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] InstrF,
    output logic        ValidF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata
`ifdef FETCHQ_STATS_EN
   ,output logic [31:0] fetch_bubble_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] head_q, head_d;
    logic [CW-1:0] count_q, count_d, live_q, live_d, disc_q, disc_d;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   pc_mem_d [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];
    logic [AW-1:0] wr_slot, gnt_slot;
    logic [CW:0]   occ;
    logic          valid, pop, gnt, keep, drop;

    always_comb begin
        occ       = {1'b0, count_q} + {1'b0, live_q} + {1'b0, disc_q};
        valid     = count_q != '0;
        imem_req  = !rst && !PCSrcE && (occ < (CW+1)'(DEPTH));
        imem_addr = fetch_pc_q;
        gnt       = imem_req && imem_gnt;
        keep      = imem_rvalid && disc_q == '0 && live_q != '0;
        drop      = imem_rvalid && disc_q != '0;
        pop       = valid && !StallF;
        wr_slot   = head_q + count_q[AW-1:0];
        gnt_slot  = wr_slot + live_q[AW-1:0];
        ValidF    = valid;
        PCF       = valid ? pc_mem_q[head_q] : 32'h0;
        InstrF    = valid ? instr_mem_q[head_q] : 32'h0000_0013;
        PCPlus4F  = PCF + 32'd4;
    end

    // Slots are reserved at grant time: a granted pc lands behind all queued and live entries.
    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        if (gnt) pc_mem_d[gnt_slot] = fetch_pc_q;
        if (keep && !PCSrcE) instr_mem_d[wr_slot] = imem_rdata;
        fetch_pc_d = PCSrcE ? (PCTargetE & ~32'd3) : (gnt ? fetch_pc_q + 32'd4 : fetch_pc_q);
        head_d     = PCSrcE ? '0 : head_q + AW'(pop);
        count_d    = PCSrcE ? '0 : count_q + CW'(keep) - CW'(pop);
        live_d     = PCSrcE ? '0 : live_q + CW'(gnt) - CW'(keep);
        disc_d     = PCSrcE ? disc_q + live_q - CW'(imem_rvalid && (disc_q != '0 || live_q != '0))
                            : disc_q - CW'(drop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            head_q      <= '0;
            count_q     <= '0;
            live_q      <= '0;
            disc_q      <= '0;
            pc_mem_q    <= '{default: '0};
            instr_mem_q <= '{default: '0};
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            head_q      <= head_d;
            count_q     <= count_d;
            live_q      <= live_d;
            disc_q      <= disc_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

`ifdef FETCHQ_STATS_EN
    logic [31:0] bubble_q, bubble_d;

    always_comb bubble_d = (!valid && !StallF && bubble_q != '1) ? bubble_q + 32'd1 : bubble_q;

    always_ff @(posedge clk) begin
        if (rst) bubble_q <= '0;
        else     bubble_q <= bubble_d;
    end

    assign fetch_bubble_cnt = bubble_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a queue-based model of fetch_queue.
module tb_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h100;

    logic        clk = 0, rst = 1, StallF = 0, PCSrcE = 0;
    logic [31:0] PCTargetE = 0;
    logic [31:0] PCF, PCPlus4F, InstrF, imem_addr;
    logic        ValidF, imem_req;
    logic        imem_gnt = 0, imem_rvalid = 0;
    logic [31:0] imem_rdata = 0;
`ifdef FETCHQ_STATS_EN
    logic [31:0] fetch_bubble_cnt;
`endif

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrF(InstrF), .ValidF(ValidF),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
`ifdef FETCHQ_STATS_EN
       ,.fetch_bubble_cnt(fetch_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    int          checks = 0, errors = 0, cyc = 0, lat = 1, disc = 0;
    ent_t        fifo[$];
    logic [31:0] live[$];
    logic [31:0] m_pc, m_bub;
    logic [31:0] mem_addr[$];
    int          mem_rdy[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a * 32'd7 + 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        fifo.delete();
        live.delete();
        mem_addr.delete();
        mem_rdy.delete();
        disc  = 0;
        m_pc  = RPC;
        m_bub = 0;
    endtask

    // One clock: memory drives at posedge+1, outputs checked at negedge, model steps at posedge.
    task automatic cycle();
        logic        exp_req, ev;
        logic [31:0] hpc;
        imem_rvalid = mem_rdy.size() > 0 && mem_rdy[0] <= cyc;
        imem_rdata  = imem_rvalid ? instr_of(mem_addr[0]) : $urandom;
        @(negedge clk);
        exp_req = !rst && !PCSrcE && (fifo.size() + live.size() + disc < DEPTH);
        ev      = fifo.size() > 0;
        hpc     = ev ? fifo[0].pc : 32'h0;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("ValidF", 32'(ValidF), 32'(ev));
        chk("PCF", PCF, hpc);
        chk("PCPlus4F", PCPlus4F, hpc + 32'd4);
        chk("InstrF", InstrF, ev ? fifo[0].instr : 32'h0000_0013);
`ifdef FETCHQ_STATS_EN
        chk("bubble_cnt", fetch_bubble_cnt, m_bub);
`endif
        if (imem_req && imem_gnt) begin
            mem_addr.push_back(imem_addr);
            mem_rdy.push_back(cyc + lat);
        end
        @(posedge clk);
        if (imem_rvalid) begin
            void'(mem_addr.pop_front());
            void'(mem_rdy.pop_front());
        end
        if (rst) model_reset();
        else begin
            if (!ev && !StallF && m_bub != 32'hFFFF_FFFF) m_bub++;
            if (PCSrcE) begin
                disc = disc + live.size() - ((imem_rvalid && disc + live.size() > 0) ? 1 : 0);
                live.delete();
                fifo.delete();
                m_pc = {PCTargetE[31:2], 2'b00};
            end else begin
                if (ev && !StallF) void'(fifo.pop_front());
                if (imem_rvalid) begin
                    if (disc > 0) disc--;
                    else if (live.size() > 0) fifo.push_back('{pc: live.pop_front(), instr: imem_rdata});
                end
                if (exp_req && imem_gnt) begin
                    live.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        repeat (2) cycle();
        rst = 0; imem_gnt = 1; lat = 1;
        repeat (8) cycle();
        StallF = 1;
        repeat (6) cycle();
        StallF = 0;
        repeat (8) cycle();
        lat = 3;
        repeat (6) cycle();
        PCSrcE = 1; PCTargetE = 32'h200;
        cycle();
        PCSrcE = 0;
        repeat (10) cycle();
        lat = 1;
        repeat (6) cycle();
        PCSrcE = 1; PCTargetE = 32'h300;
        cycle();
        PCSrcE = 0;
        repeat (8) cycle();
        PCSrcE = 1; PCTargetE = 32'hFFFF_FFFC;
        cycle();
        PCSrcE = 0;
        repeat (6) cycle();
        PCSrcE = 1; PCTargetE = 32'h403;
        cycle();
        PCSrcE = 0;
        repeat (5) cycle();
        rst = 1;
        cycle();
        rst = 0; imem_gnt = 0;
        repeat (5) cycle();
        imem_gnt = 1;
        repeat (6) cycle();
        repeat (400) begin
            imem_gnt  = $urandom_range(0, 3) != 0;
            StallF    = $urandom_range(0, 3) == 0;
            lat       = $urandom_range(1, 4);
            PCSrcE    = $urandom_range(0, 15) == 0;
            PCTargetE = $urandom;
            rst       = $urandom_range(0, 99) == 0;
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
